reorder_buffer: RTL
===================

# reorder_buffer

In-order retirement buffer for the out-of-order RISC-V core, sitting between issue/CDB and the branch predictor. Allocates one entry per issued instruction, collects results from the common data bus, and retires the head entry in program order. Retirement drives the commit interface that the branch predictor consumes (`rob_commit`, `rob_pc_commit`, `rob_op_commit`, `rob_op_type`, `rob_result`, `rob_pc_result`). On a branch mispredict it raises `roll_back` and flushes.

## Interface
- `ROB_SIZE`, 16: entry count; power of 2.
- `TAG_W`, 4: log2(`ROB_SIZE`).
- `clk_in` in 1: system clock.
- `rst_in` in 1: reset, asynchronous, active-low.
- `rdy_in` in 1: pause when low.
- `issue_valid` in 1: allocate request.
- `issue_op` in 6: opcode (operaType.v encoding).
- `issue_op_type` in 3: op type (`BType`, …).
- `issue_pc` in 32: instruction PC.
- `issue_pred_taken` in 1: predictor's taken guess (branches only).
- `issue_rd` in 5: destination register.
- `issue_tag` out TAG_W: tail index, i.e. the tag given to this cycle's issue.
- `rob_full` out 1: count == ROB_SIZE.
- `wb_valid` in 1: CDB result valid.
- `wb_tag` in TAG_W: target entry.
- `wb_value` in 32: result. Branch: bit0 = taken. JALR: link value.
- `wb_target` in 32: branch/JALR target address.
- `rob_commit` out 1: one-cycle retire pulse.
- `rob_pc_commit` out 32: PC of retired entry.
- `rob_op_commit` out 6: opcode of retired entry.
- `rob_op_type` out 3: op type of retired entry.
- `rob_result` out 32: BType {31'b0,taken}; JALR `wb_target`; else `wb_value`.
- `rob_pc_result` out 32: actual next PC (taken/JAL(R) ? target : pc+4).
- `commit_rd` out 5, `commit_value` out 32: register writeback of retired entry (`wb_value`).
- `roll_back` out 1: one-cycle flush pulse.
- `roll_back_pc` out 32: restart PC (= `rob_pc_result`).

## Operation
- Per-entry state: busy, ready, op, op_type, pc, pred_taken, rd, value, target. Pointers head and tail (TAG_W bits, wrap modulo ROB_SIZE). count is (TAG_W+1) bits.
- Allocate: `issue_valid && !rob_full` at an edge writes the entry at tail, sets busy=1 and ready=0, then tail+1 and count+1. An issue while full is dropped. `rob_full` is evaluated from pre-edge count, so a same-edge commit does not admit the issue.
- Writeback: `wb_valid` with busy[wb_tag] stores value/target and sets ready=1. Writeback to a non-busy entry is ignored.
- Commit: if busy[head] && ready[head] at an edge:
  - register all commit outputs and pulse `rob_commit`;
  - clear busy[head]; head+1; count-1.
  - At most one commit per cycle.
- Mispredict applies to BType entries where taken != pred_taken. The commit proceeds normally, and in the same cycle:
  - `roll_back`=1 with `roll_back_pc` = actual next PC;
  - all busy bits cleared, head=tail=0, count=0;
  - any issue or writeback on that edge is discarded.
- JALR never sets `roll_back`; the predictor redirects from `rob_result`.
- Simultaneous issue + commit (not full) leaves count unchanged. Simultaneous writeback + commit to different entries are both honoured.

## Timing
- Reset (`rst_in`=0, async) clears all outputs, pointers, count and busy/ready to 0, immediately.
- `rdy_in`=0: all state holds; `rob_commit` and `roll_back` are 0 that cycle.
- `issue_tag` and `rob_full` are combinational from tail/count. All other outputs are registered.
- Writeback at edge k gives an earliest commit at edge k+1. Outputs are visible during cycle k+1→k+2.
- Issue at edge k, writeback no earlier than edge k+1.
- Non-commit cycles: `rob_commit`=0, `roll_back`=0. The data outputs hold their last value.

## Test plan
- Reset then 3 ALU issues (pc 0x0,0x4,0x8), writebacks in order 2,0,1 → commits in tag order 0,1,2 with `rob_pc_commit` 0x0,0x4,0x8, one per cycle, starting the cycle after tag0's writeback.
- Fill 16 entries → `rob_full`=1. A 17th issue is dropped and tail is unchanged. One commit, then issue accepted with `issue_tag`=0 (wrap).
- BType pc=0x100, pred_taken=0, wb_value=1, target=0x180 → `rob_commit`=1, `rob_result`=1, `rob_pc_result`=0x180, `roll_back`=1, `roll_back_pc`=0x180. Younger entries are flushed and the next `issue_tag`=0.
- BType correctly predicted not-taken at pc=0x200 → `rob_result`=0, `rob_pc_result`=0x204, `roll_back`=0.
- JALR pc=0x40, wb_value=0x44, target=0x300 → `rob_result`=0x300, `commit_value`=0x44, `roll_back`=0.
- Hold `rdy_in`=0 with ready head → no commit. Assert `rst_in`=0 mid-stream → all outputs 0 without a clock edge.

Source files
------------

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates at tail on issue, collects CDB results,
// retires the head in program order and flushes everything on a branch mispredict.
module reorder_buffer #(
    parameter int         ROB_SIZE  = 16,
    parameter int         TAG_W     = 4,
    parameter logic [2:0] OPT_BTYPE = 3'd1,
    parameter logic [2:0] OPT_JAL   = 3'd2,
    parameter logic [2:0] OPT_JALR  = 3'd3
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             issue_valid,
    input  logic [5:0]       issue_op,
    input  logic [2:0]       issue_op_type,
    input  logic [31:0]      issue_pc,
    input  logic             issue_pred_taken,
    input  logic [4:0]       issue_rd,
    output logic [TAG_W-1:0] issue_tag,
    output logic             rob_full,
    input  logic             wb_valid,
    input  logic [TAG_W-1:0] wb_tag,
    input  logic [31:0]      wb_value,
    input  logic [31:0]      wb_target,
    output logic             rob_commit,
    output logic [31:0]      rob_pc_commit,
    output logic [5:0]       rob_op_commit,
    output logic [2:0]       rob_op_type,
    output logic [31:0]      rob_result,
    output logic [31:0]      rob_pc_result,
    output logic [4:0]       commit_rd,
    output logic [31:0]      commit_value,
    output logic             roll_back,
    output logic [31:0]      roll_back_pc
);

    localparam logic [TAG_W:0] FULL_COUNT = (TAG_W+1)'(ROB_SIZE);

    logic [ROB_SIZE-1:0] r_busy;
    logic [ROB_SIZE-1:0] r_ready;
    logic [5:0]          r_op         [ROB_SIZE];
    logic [2:0]          r_op_type    [ROB_SIZE];
    logic [31:0]         r_pc         [ROB_SIZE];
    logic                r_pred_taken [ROB_SIZE];
    logic [4:0]          r_rd         [ROB_SIZE];
    logic [31:0]         r_value      [ROB_SIZE];
    logic [31:0]         r_target     [ROB_SIZE];

    logic [TAG_W-1:0] r_head;
    logic [TAG_W-1:0] r_tail;
    logic [TAG_W:0]   r_count;

    logic        r_commit;
    logic [31:0] r_pc_commit;
    logic [5:0]  r_op_commit;
    logic [2:0]  r_op_type_commit;
    logic [31:0] r_result;
    logic [31:0] r_pc_result;
    logic [4:0]  r_commit_rd;
    logic [31:0] r_commit_value;
    logic        r_roll_back;
    logic [31:0] r_roll_back_pc;

    logic        w_full;
    logic        w_issue;
    logic        w_wb;
    logic        w_commit;
    logic        w_is_b;
    logic        w_is_jump;
    logic        w_taken;
    logic        w_mispredict;
    logic [31:0] w_result;
    logic [31:0] w_pc_result;

    assign w_full   = (r_count == FULL_COUNT);
    assign w_issue  = issue_valid && !w_full;
    assign w_wb     = wb_valid && r_busy[wb_tag];
    assign w_commit = r_busy[r_head] && r_ready[r_head];

    assign w_is_b       = (r_op_type[r_head] == OPT_BTYPE);
    assign w_is_jump    = (r_op_type[r_head] == OPT_JAL) || (r_op_type[r_head] == OPT_JALR);
    assign w_taken      = r_value[r_head][0];
    assign w_mispredict = w_commit && w_is_b && (w_taken != r_pred_taken[r_head]);

    always_comb begin
        w_result    = r_value[r_head];
        w_pc_result = r_pc[r_head] + 32'd4;
        if (w_is_b) begin
            w_result = {31'b0, w_taken};
        end else if (r_op_type[r_head] == OPT_JALR) begin
            w_result = r_target[r_head];
        end
        if ((w_is_b && w_taken) || w_is_jump) begin
            w_pc_result = r_target[r_head];
        end
    end

    // Per-entry status bits; a flush wins over any same-edge issue or writeback.
    genvar gi;
    generate
        for (gi = 0; gi < ROB_SIZE; gi = gi + 1) begin : g_entry
            always_ff @(posedge clk_in or negedge rst_in) begin
                if (!rst_in) begin
                    r_busy[gi]  <= 1'b0;
                    r_ready[gi] <= 1'b0;
                end else if (rdy_in) begin
                    if (w_mispredict) begin
                        r_busy[gi]  <= 1'b0;
                        r_ready[gi] <= 1'b0;
                    end else if (w_issue && (r_tail == TAG_W'(gi))) begin
                        r_busy[gi]  <= 1'b1;
                        r_ready[gi] <= 1'b0;
                    end else begin
                        if (w_commit && (r_head == TAG_W'(gi))) begin
                            r_busy[gi] <= 1'b0;
                        end
                        if (w_wb && (wb_tag == TAG_W'(gi))) begin
                            r_ready[gi] <= 1'b1;
                        end
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_in) begin
        if (rdy_in && !w_mispredict) begin
            if (w_issue) begin
                r_op[r_tail]         <= issue_op;
                r_op_type[r_tail]    <= issue_op_type;
                r_pc[r_tail]         <= issue_pc;
                r_pred_taken[r_tail] <= issue_pred_taken;
                r_rd[r_tail]         <= issue_rd;
            end
            if (w_wb) begin
                r_value[wb_tag]  <= wb_value;
                r_target[wb_tag] <= wb_target;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_head           <= '0;
            r_tail           <= '0;
            r_count          <= '0;
            r_commit         <= 1'b0;
            r_pc_commit      <= '0;
            r_op_commit      <= '0;
            r_op_type_commit <= '0;
            r_result         <= '0;
            r_pc_result      <= '0;
            r_commit_rd      <= '0;
            r_commit_value   <= '0;
            r_roll_back      <= 1'b0;
            r_roll_back_pc   <= '0;
        end else if (rdy_in) begin
            r_commit    <= w_commit;
            r_roll_back <= w_mispredict;
            if (w_commit) begin
                r_pc_commit      <= r_pc[r_head];
                r_op_commit      <= r_op[r_head];
                r_op_type_commit <= r_op_type[r_head];
                r_result         <= w_result;
                r_pc_result      <= w_pc_result;
                r_commit_rd      <= r_rd[r_head];
                r_commit_value   <= r_value[r_head];
            end
            if (w_mispredict) begin
                r_roll_back_pc <= w_pc_result;
                r_head         <= '0;
                r_tail         <= '0;
                r_count        <= '0;
            end else begin
                if (w_commit) begin
                    r_head <= r_head + 1'b1;
                end
                if (w_issue) begin
                    r_tail <= r_tail + 1'b1;
                end
                case ({w_issue, w_commit})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end else begin
            r_commit    <= 1'b0;
            r_roll_back <= 1'b0;
        end
    end

    assign issue_tag     = r_tail;
    assign rob_full      = w_full;
    assign rob_commit    = r_commit;
    assign rob_pc_commit = r_pc_commit;
    assign rob_op_commit = r_op_commit;
    assign rob_op_type   = r_op_type_commit;
    assign rob_result    = r_result;
    assign rob_pc_result = r_pc_result;
    assign commit_rd     = r_commit_rd;
    assign commit_value  = r_commit_value;
    assign roll_back     = r_roll_back;
    assign roll_back_pc  = r_roll_back_pc;

endmodule
